// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding RISC-V load/store unit. It accepts one access from the
// execute stage and checks funct3 legality and alignment. It then drives one
// word-aligned memory access with byte enables and lane-replicated store data.
// It waits for mem_ack, but only for ACK_TIMEOUT cycles. It returns a
// one-cycle response carrying the sign- or zero-extended load data, or an
// error code.
//
// Parameters
//   ACK_TIMEOUT  cycles mem_req may wait for mem_ack before abort (1..65535)
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_store           1 = store, 0 = load
//   req_funct3          RISC-V funct3 (width and sign)
//   req_addr, req_wdata effective address, store data
//   mem_req/we/addr/be/wdata   memory access (held stable during access)
//   mem_ack, mem_rdata  memory completion and read word
//   rsp_valid           one-cycle response strobe
//   rsp_rdata, rsp_err  extended load data, error (00 ok, 01 misaligned,
//                       10 timeout, 11 illegal funct3)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned XLEN  = 32;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        cap_funct3;
    logic [1:0]        cap_off;
    logic              cap_store;

    logic              legal_c;
    logic              misaligned_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [XLEN-1:0]   load_data_c;

    // Request decode: legality, alignment, byte enables, store lane replication
    always_comb begin
        legal_c      = 1'b0;
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = '0;

        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = !req_store;
            default:                legal_c = 1'b0;
        endcase

        // funct3[1:0] gives the access size for every legal encoding
        unique case (req_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = req_addr[0];
                be_c         = 4'b0011 << req_addr[1:0];
                wdata_c      = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned_c = |req_addr[1:0];
                be_c         = 4'b1111;
                wdata_c      = req_wdata;
            end
        endcase
    end

    // Load extraction from the returned word using the captured offset/funct3
    always_comb begin
        byte_c      = mem_rdata[{cap_off, 3'b000} +: 8];
        half_c      = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data_c = mem_rdata;

        unique case (cap_funct3)
            3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_data_c = {24'h000000, byte_c};
            3'b101:  load_data_c = {16'h0000, half_c};
            default: load_data_c = mem_rdata;
        endcase

        if (cap_store) begin
            load_data_c = '0;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_funct3 <= 3'b000;
            cap_off    <= 2'b00;
            cap_store  <= 1'b0;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= ERR_OK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        cap_funct3 <= req_funct3;
                        cap_off    <= req_addr[1:0];
                        cap_store  <= req_store;
                        // Illegal funct3 is reported ahead of misalignment
                        if (!legal_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= ERR_ILLEGAL;
                        end else if (misaligned_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= ERR_MISALIGN;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                        end
                    end
                end

                ACCESS: begin
                    // An ack in the last permitted cycle beats the timeout
                    if (mem_ack) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data_c;
                        rsp_err   <= ERR_OK;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= ERR_OK;
                    cnt       <= '0;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench for load_store_unit (ACK_TIMEOUT = 4). The expected
// responses are queued when a request is driven. A monitor pops and compares
// them on every rsp_valid. A memory responder acks after a programmable number
// of mem_req cycles and records the access fields.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    int          ack_cycle = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    bit          saw_req = 0;
    logic [31:0] rword = '0;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_be = '0;
    logic        seen_we = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: ack on the ack_cycle-th cycle of mem_req (0 = never)
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_0F0F;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                wait_cnt++;
                saw_req = 1'b1;
                if (wait_cnt == 1) begin
                    seen_addr  = mem_addr;
                    seen_be    = mem_be;
                    seen_we    = mem_we;
                    seen_wdata = mem_wdata;
                end else begin
                    check("hold_addr", mem_addr, seen_addr);
                    check("hold_wdata", mem_wdata, seen_wdata);
                    check("hold_ctl", {27'd0, mem_we, mem_be}, {27'd0, seen_we, seen_be});
                end
                mem_ack   = (wait_cnt == ack_cycle);
                mem_rdata = mem_ack ? rword : 32'h5A5A_0F0F;
            end else begin
                if (wait_cnt > 0) req_cycles = wait_cnt;
                wait_cnt  = 0;
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_0F0F;
            end
        end
    end

    // Response monitor: pop the scoreboard on every rsp_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_rsp(input int c0);
        int n = 0;
        while (rsp_cnt == c0 && n < 60) begin
            tick();
            n++;
        end
        check("rsp_count", 32'(rsp_cnt - c0), 32'd1);
    endtask

    // One complete transaction with mem-side and latency checks.
    // ackc = mem_req cycle carrying the ack (0 = never); acc = access expected.
    task automatic run(input string tag, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ackc, input logic [31:0] rw,
                       input logic [31:0] er, input logic [1:0] ee,
                       input bit acc, input logic [3:0] be, input logic [31:0] mwd);
        exp_t e;
        int   c0;
        int   d;
        int   lat;
        wait_ready();
        ack_cycle = ackc;
        rword     = rw;
        saw_req   = 1'b0;
        e.rdata   = er;
        e.err     = ee;
        sb_q.push_back(e);
        c0         = rsp_cnt;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        d          = cyc;
        tick();
        req_valid  = 1'b0;
        wait_rsp(c0);
        lat = !acc ? 1 : ((ackc == 0) ? 1 + int'(TO) : 1 + ackc);
        check({tag, "_latency"}, 32'(rsp_cyc - d), 32'(lat));
        check({tag, "_memreq"}, {31'd0, saw_req}, {31'd0, acc});
        if (acc) begin
            check({tag, "_req_cycles"}, 32'(req_cycles), 32'((ackc == 0) ? int'(TO) : ackc));
            check({tag, "_mem_addr"}, seen_addr, {a[31:2], 2'b00});
            check({tag, "_mem_be"}, {28'd0, seen_be}, {28'd0, be});
            check({tag, "_mem_we"}, {31'd0, seen_we}, {31'd0, st});
            if (st) check({tag, "_mem_wdata"}, seen_wdata, mwd);
        end
        tick();
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d compares", n_cmp);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   c0;
        int   d;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        tick();
        tick();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp", {rsp_rdata[29:0], rsp_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        //   tag     st  f3      addr          wdata         ackc rword         exp_rdata     err    acc be       mem_wdata
        run("lb",    0, 3'b000, 32'h0000_1003, 32'h0,        1, 32'h80FF_FF00, 32'hFFFF_FF80, 2'b00, 1, 4'b1000, 32'h0);
        run("sh",    1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 1, 32'hFFFF_FFFF, 32'h0,        2'b00, 1, 4'b1100, 32'hABCD_ABCD);
        run("lw_mis",0, 3'b010, 32'h0000_3001, 32'h0,        1, 32'h0,        32'h0,         2'b01, 0, 4'b0000, 32'h0);
        run("ill_ld",0, 3'b011, 32'h0000_3000, 32'h0,        1, 32'h0,        32'h0,         2'b11, 0, 4'b0000, 32'h0);
        run("ill_mis",0,3'b011, 32'h0000_3001, 32'h0,        1, 32'h0,        32'h0,         2'b11, 0, 4'b0000, 32'h0);
        run("ill_st",1, 3'b100, 32'h0000_3000, 32'h0,        1, 32'h0,        32'h0,         2'b11, 0, 4'b0000, 32'h0);
        run("lh_mis",0, 3'b001, 32'h0000_3003, 32'h0,        1, 32'h0,        32'h0,         2'b01, 0, 4'b0000, 32'h0);
        run("lbu",   0, 3'b100, 32'h0000_1001, 32'h0,        2, 32'h1234_80F0, 32'h0000_0080, 2'b00, 1, 4'b0010, 32'h0);
        run("lh",    0, 3'b001, 32'h0000_4000, 32'h0,        1, 32'h0000_9ABC, 32'hFFFF_9ABC, 2'b00, 1, 4'b0011, 32'h0);
        run("lw",    0, 3'b010, 32'h0000_5004, 32'h0,        1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1, 4'b1111, 32'h0);
        run("sb",    1, 3'b000, 32'h0000_6001, 32'hAABB_CC5A, 1, 32'h0,        32'h0,         2'b00, 1, 4'b0010, 32'h5A5A_5A5A);
        run("sw",    1, 3'b010, 32'h0000_7000, 32'h0102_0304, 3, 32'h0,        32'h0,         2'b00, 1, 4'b1111, 32'h0102_0304);
        run("tmo",   0, 3'b010, 32'h0000_9000, 32'h0,        0, 32'h1111_1111, 32'h0,        2'b10, 1, 4'b1111, 32'h0);
        run("ack_last",0,3'b010,32'h0000_9004, 32'h0,        4, 32'h1357_2468, 32'h1357_2468, 2'b00, 1, 4'b1111, 32'h0);

        // Delayed LHU with req_valid pulsed while the access is pending
        wait_ready();
        ack_cycle  = 3;
        rword      = 32'h8001_0000;
        e.rdata    = 32'h0000_8001;
        e.err      = 2'b00;
        sb_q.push_back(e);
        c0         = rsp_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b101;
        req_addr   = 32'h0000_0002;
        d          = cyc;
        tick();
        req_funct3 = 3'b011;
        req_addr   = 32'h0000_0001;
        tick();
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid  = 1'b0;
        wait_rsp(c0);
        check("lhu_latency", 32'(rsp_cyc - d), 32'd4);
        check("lhu_req_cycles", 32'(req_cycles), 32'd3);
        check("lhu_be", {28'd0, seen_be}, 32'h0000_000C);
        repeat (4) tick();
        check("lhu_no_extra", 32'(rsp_cnt - c0), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of an access: no response, mem_req drops at once
        wait_ready();
        ack_cycle  = 0;
        c0         = rsp_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_8000;
        tick();
        req_valid  = 1'b0;
        tick();
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", {31'd0, mem_req}, 32'd0);
        check("rst_ready_async", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_async", {31'd0, rsp_valid}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rst_no_rsp", 32'(rsp_cnt - c0), 32'd0);
        check("rst_ready_after", {31'd0, req_ready}, 32'd1);

        run("post_rst", 0, 3'b000, 32'h0000_0A02, 32'h0, 1, 32'h0071_0000, 32'h0000_0071, 2'b00, 1, 4'b0100, 32'h0);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 ACK_TIMEOUT, default 255, maximum cycles mem_req waits for mem_ack before abort; legal range 1..65535.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  access request from the execute stage.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V funct3 giving access width and sign.
REQ-008 req_addr  in  32  effective address, the ALU add result.
REQ-009 req_wdata  in  32  store data (rs2).
REQ-010 mem_req  out  1  memory access strobe.
REQ-011 mem_we  out  1  memory write enable.
REQ-012 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-013 mem_be  out  4  byte enables, bit i = byte lane i.
REQ-014 mem_wdata  out  32  lane-aligned store data.
REQ-015 mem_ack  in  1  memory completed the access.
REQ-016 mem_rdata  in  32  read word, valid when mem_ack=1.
REQ-017 rsp_valid  out  1  one-cycle result strobe.
REQ-018 rsp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-019 rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE with req_valid=1: request captured; legal and aligned -> ACCESS next cycle, else -> RESP with error and no mem_req.
REQ-022 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others give err 11.
REQ-023 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0 -> err 01; illegal funct3 takes priority over misaligned.
REQ-024 ACCESS: mem_req=1; mem_we, mem_addr, mem_be and mem_wdata driven from captured registers and held stable until exit.
REQ-025 mem_be: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; same for loads.
REQ-026 Store data replicated across lanes: byte {4{b}}, half {2{h}}, word unchanged.
REQ-027 ACCESS exits to RESP on the edge sampling mem_ack=1; mem_rdata captured on that edge.
REQ-028 Load extraction selects the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-029 Timeout counter cleared on ACCESS entry, +1 per ACCESS cycle without ack; ACK_TIMEOUT cycles without ack -> RESP with err 10.
REQ-030 mem_ack in the last permitted cycle completes normally (err 00); ack wins over timeout.
REQ-031 RESP lasts exactly one cycle with rsp_valid=1, then IDLE; rsp_rdata/rsp_err valid only while rsp_valid=1.
REQ-032 Best-case load latency: accept at T, mem_req at T+1, ack at T+1, rsp_valid at T+2; error responses at T+1.
REQ-033 req_valid outside IDLE is ignored; mem_ack outside ACCESS is ignored.
REQ-034 A new request may be accepted in the cycle following RESP.

Reset
REQ-035 rst_n low immediately forces IDLE, req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, counter=0.
REQ-036 Reset during ACCESS abandons the access with no response; mem_req drops asynchronously.

Verification
REQ-037 LB addr 0x1003, mem_rdata 0x80FF_FF00 -> mem_addr 0x1000, mem_be 1000, rsp_rdata 0xFFFF_FF80, err 00.
REQ-038 SH addr 0x2002, wdata 0x1234_ABCD -> mem_we=1, mem_be 1100, mem_wdata 0xABCD_ABCD, rsp_rdata 0.
REQ-039 LW addr 0x3001 -> no mem_req, rsp_valid next cycle, err 01; funct3 011 load -> err 11.
REQ-040 ACK_TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then err 10; ack in 4th cycle -> err 00.
REQ-041 LHU addr 0x0002, ack delayed 3 cycles, rdata 0x8001_0000 -> rsp_rdata 0x0000_8001; req_valid during wait ignored.
REQ-042 rst_n asserted mid-ACCESS -> mem_req=0 immediately; no rsp_valid; req_ready=1 after release.
